// File: rtl/chkmon_pkg.sv
// ============================================================================
// Module   : chkmon_pkg
// Purpose  : Shared types, default code bases and code-to-channel decoding
//            for the checkbit monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package chkmon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2,
    ST_FAIL   = 2'd3
  } state_e;

  localparam logic [15:0] DEF_START_BASE = 16'hAB40;
  localparam logic [15:0] DEF_END_BASE   = 16'hAB51;

  typedef struct packed {
    logic       hit;
    logic [3:0] ch;
  } decode_t;

  // hit when base <= code < base+nch; ch is the offset into the range
  function automatic decode_t decode_code(input logic [31:0] code,
                                          input logic [31:0] base,
                                          input int unsigned nch);
    logic [31:0] off;
    decode_t     r;
    off   = code - base;
    r.hit = (code >= base) && (off < nch);
    r.ch  = off[3:0];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chkmon_sync.sv
// ============================================================================
// Module   : chkmon_sync
// Purpose  : Two-flop synchroniser for the pad status code followed by a
//            one-cycle stability compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chkmon_sync #(
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          RSTB,
  input  logic [CW-1:0] checkbits,
  output logic [CW-1:0] code,
  output logic          seen
);

  logic [CW-1:0] meta_q, meta_d;
  logic [CW-1:0] sync_q, sync_d;
  logic [CW-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = checkbits;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign code = sync_q;
  assign seen = (sync_q == prev_q);

endmodule

`default_nettype wire

// File: rtl/checkbit_monitor.sv
// ============================================================================
// Module   : checkbit_monitor
// Purpose  : Watches a pad-driven status code, times per-channel test runs
//            between start/end codes and records pass/fail per channel.
//            Optional macro CHKMON_STRICT_EN enables protocol-error checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module checkbit_monitor
  import chkmon_pkg::*;
#(
  parameter int            CW         = 16,
  parameter int            NCH        = 4,
  parameter logic [CW-1:0] START_BASE = CW'(DEF_START_BASE),
  parameter logic [CW-1:0] END_BASE   = CW'(DEF_END_BASE),
  parameter int            MIN_RUN    = 10000,
  parameter int            TIMEOUT    = 100000,
  parameter int            TW         = 24
) (
  input  logic                                    clock,
  input  logic                                    RSTB,
  input  logic [CW-1:0]                           checkbits,
  input  logic                                    clear,
  output logic                                    active,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] active_ch,
  output logic [NCH-1:0]                          done,
  output logic [NCH-1:0]                          pass,
  output logic                                    timeout_flag,
  output logic [TW-1:0]                           cycles,
  output logic                                    cycles_vld,
  output logic                                    proto_err
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef CHKMON_STRICT_EN
  localparam logic STRICT_EN = 1'b1;
`else
  localparam logic STRICT_EN = 1'b0;
`endif

  if (!(((int'(START_BASE) + NCH) <= int'(END_BASE)) ||
        ((int'(END_BASE) + NCH) <= int'(START_BASE))) ||
      (TIMEOUT <= MIN_RUN)) begin : g_cfg_err
    $error("checkbit_monitor: overlapping code ranges or TIMEOUT <= MIN_RUN");
  end

  logic [CW-1:0] code;
  logic          seen;

  chkmon_sync #(.CW(CW)) u_sync (
    .clock     (clock),
    .RSTB      (RSTB),
    .checkbits (checkbits),
    .code      (code),
    .seen      (seen)
  );

  state_e         state_q, state_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [CHW-1:0] ach_q, ach_d;
  logic [NCH-1:0] done_q, done_d, pass_q, pass_d;
  logic           tmo_q, tmo_d, vld_q, vld_d, proto_q, proto_d;
  logic [TW-1:0]  cycles_q, cycles_d;
  logic [CW-1:0]  last_q, last_d;

  decode_t w_start, w_end;
  logic    w_end_own, w_fresh;

  assign w_start   = decode_code(32'(code), 32'(START_BASE), NCH);
  assign w_end     = decode_code(32'(code), 32'(END_BASE), NCH);
  assign w_end_own = seen && w_end.hit && (w_end.ch == 4'(ach_q));
  // Level-held codes (launching start, accepted end) must not look like new
  // protocol events, so strict checks only react to a code change.
  assign w_fresh   = seen && (code != last_q);

  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ach_q    <= '0;
      done_q   <= '0;
      pass_q   <= '0;
      tmo_q    <= 1'b0;
      vld_q    <= 1'b0;
      proto_q  <= 1'b0;
      cycles_q <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ach_q    <= ach_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
      vld_q    <= vld_d;
      proto_q  <= proto_d;
      cycles_q <= cycles_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ach_d    = ach_q;
    done_d   = done_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    vld_d    = 1'b0;
    proto_d  = proto_q;
    cycles_d = cycles_q;
    last_d   = seen ? code : last_q;

    case (state_q)
      ST_IDLE: begin
        if (seen && w_start.hit) begin
          state_d        = ST_RUN;
          ach_d          = CHW'(w_start.ch);
          cnt_d          = TW'(1);
          done_d[ach_d]  = 1'b0;
          pass_d[ach_d]  = 1'b0;
        end else if (STRICT_EN && w_fresh && w_end.hit) begin
          proto_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q != {TW{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (cnt_q == TW'(TIMEOUT)) begin
          state_d       = ST_FAIL;
          done_d[ach_q] = 1'b1;
          pass_d[ach_q] = 1'b0;
          tmo_d         = 1'b1;
          cycles_d      = cnt_q;
          vld_d         = 1'b1;
        end else if (w_end_own && (cnt_q >= TW'(MIN_RUN))) begin
          state_d       = ST_REPORT;
          done_d[ach_q] = 1'b1;
          pass_d[ach_q] = 1'b1;
          cycles_d      = cnt_q;
          vld_d         = 1'b1;
        end else if (STRICT_EN && w_fresh &&
                     (w_start.hit || (w_end.hit && !w_end_own))) begin
          state_d       = ST_FAIL;
          proto_d       = 1'b1;
          done_d[ach_q] = 1'b1;
          pass_d[ach_q] = 1'b0;
          cycles_d      = cnt_q;
          vld_d         = 1'b1;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      ST_FAIL:   state_d = ST_FAIL;
      default:   state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      done_d   = '0;
      pass_d   = '0;
      tmo_d    = 1'b0;
      vld_d    = 1'b0;
      proto_d  = 1'b0;
      cycles_d = '0;
    end
  end

  always_comb begin
    active       = (state_q == ST_RUN);
    active_ch    = ach_q;
    done         = done_q;
    pass         = pass_q;
    timeout_flag = tmo_q;
    cycles       = cycles_q;
    cycles_vld   = vld_q;
    proto_err    = proto_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_checkbit_monitor.sv
// ============================================================================
// Module   : tb_checkbit_monitor
// Purpose  : Directed self-checking bench for checkbit_monitor with run
//            lengths scaled down (MIN_RUN 1000, TIMEOUT 4000).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_checkbit_monitor;

  localparam int CW      = 16;
  localparam int NCH     = 4;
  localparam int TW      = 24;
  localparam int MIN_RUN = 1000;
  localparam int TIMEOUT = 4000;

`ifdef CHKMON_STRICT_EN
  localparam logic [31:0] EXP_X_ACTIVE = 0;
  localparam logic [31:0] EXP_X_PROTO  = 1;
  localparam logic [31:0] EXP_X_DONE   = 4'b0001;
`else
  localparam logic [31:0] EXP_X_ACTIVE = 1;
  localparam logic [31:0] EXP_X_PROTO  = 0;
  localparam logic [31:0] EXP_X_DONE   = 4'b0000;
`endif

  logic           clock = 1'b0;
  logic           RSTB;
  logic           clear;
  logic [CW-1:0]  checkbits;
  logic           active;
  logic [1:0]     active_ch;
  logic [NCH-1:0] done, pass;
  logic           timeout_flag;
  logic [TW-1:0]  cycles;
  logic           cycles_vld;
  logic           proto_err;

  int n_checks = 0;
  int n_errors = 0;

  checkbit_monitor #(
    .CW(CW), .NCH(NCH), .START_BASE(16'hAB40), .END_BASE(16'hAB51),
    .MIN_RUN(MIN_RUN), .TIMEOUT(TIMEOUT), .TW(TW)
  ) dut (
    .clock(clock), .RSTB(RSTB), .checkbits(checkbits), .clear(clear),
    .active(active), .active_ch(active_ch), .done(done), .pass(pass),
    .timeout_flag(timeout_flag), .cycles(cycles), .cycles_vld(cycles_vld),
    .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive a start code and measure edges until active rises (bounded).
  task automatic start_run(input string tag, input logic [15:0] code, input int ch);
    int lat;
    checkbits = code;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (active) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_ch"}, 32'(active_ch), ch);
  endtask

  initial begin
    RSTB = 1'b0; clear = 1'b0; checkbits = '0;
    #3;
    check("rst_active", 32'(active), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cycles", cycles, 0);
    check("rst_vld", 32'(cycles_vld), 0);
    step(2);
    RSTB = 1'b1;
    step(3);

    // single-cycle glitch must be filtered
    checkbits = 16'hAB40;
    step(1);
    checkbits = '0;
    step(8);
    check("glitch_active", 32'(active), 0);

    // channel 0 normal pass, end code at run cycle ~1200
    start_run("ch0", 16'hAB40, 0);
    step(1196);
    checkbits = 16'hAB51;
    step(3);
    check("ch0_vld_early", 32'(cycles_vld), 0);
    check("ch0_still_run", 32'(active), 1);
    step(1);
    check("ch0_vld", 32'(cycles_vld), 1);
    check("ch0_cycles", cycles, 1200);
    check("ch0_done", 32'(done), 4'b0001);
    check("ch0_pass", 32'(pass), 4'b0001);
    check("ch0_active", 32'(active), 0);
    step(1);
    check("ch0_vld_pulse", 32'(cycles_vld), 0);

    // channel 1: end code held from run cycle 50, accepted at MIN_RUN
    start_run("ch1", 16'hAB41, 1);
    step(49);
    checkbits = 16'hAB52;
    step(950);
    check("ch1_not_yet", 32'(cycles_vld), 0);
    step(1);
    check("ch1_vld", 32'(cycles_vld), 1);
    check("ch1_cycles", cycles, 1000);
    check("ch1_done", 32'(done), 4'b0011);
    check("ch1_pass", 32'(pass), 4'b0011);

    // channel 2: no end code -> timeout
    start_run("ch2", 16'hAB42, 2);
    step(3999);
    check("ch2_run", 32'(active), 1);
    step(1);
    check("ch2_active", 32'(active), 0);
    check("ch2_vld", 32'(cycles_vld), 1);
    check("ch2_cycles", cycles, 4000);
    check("ch2_done", 32'(done), 4'b0111);
    check("ch2_pass", 32'(pass), 4'b0011);
    check("ch2_tmo", 32'(timeout_flag), 1);
    step(1);
    checkbits = 16'hAB43;
    step(10);
    check("fail_ignore_active", 32'(active), 0);
    check("fail_ignore_ch", 32'(active_ch), 2);

    // clear returns to IDLE; held AB43 then starts channel 3
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_done", 32'(done), 0);
    check("clr_pass", 32'(pass), 0);
    check("clr_tmo", 32'(timeout_flag), 0);
    check("clr_cycles", cycles, 0);
    check("clr_active", 32'(active), 0);
    step(1);
    check("ch3_active", 32'(active), 1);
    check("ch3_ch", 32'(active_ch), 3);

    // asynchronous reset mid-run
    step(499);
    RSTB = 1'b0;
    checkbits = '0;
    #1;
    check("mrst_active", 32'(active), 0);
    check("mrst_ch", 32'(active_ch), 0);
    check("mrst_done", 32'(done), 0);
    step(2);
    RSTB = 1'b1;
    step(2);
    start_run("post", 16'hAB40, 0);
    step(1196);
    checkbits = 16'hAB51;
    step(4);
    check("post_vld", 32'(cycles_vld), 1);
    check("post_cycles", cycles, 1200);
    check("post_pass", 32'(pass), 4'b0001);

    // rerun of channel 0, then foreign end code
    start_run("rerun", 16'hAB40, 0);
    check("rerun_done_clr", 32'(done), 0);
    step(1099);
    checkbits = 16'hAB52;
    step(4);
    check("xend_active", 32'(active), EXP_X_ACTIVE);
    check("xend_proto", 32'(proto_err), EXP_X_PROTO);
    check("xend_done", 32'(done), EXP_X_DONE);
    check("xend_pass", 32'(pass), 0);
    check("xend_tmo", 32'(timeout_flag), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
